// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and selects, and runs a req/ack memory handshake
// guarded by a wait-counter watchdog.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic       error
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluXor = 3'd2;
    localparam logic [2:0] AluSlt = 3'd3;

    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StWbR,
        StExecI,
        StWbI,
        StAddr,
        StMemRd,
        StWbMem,
        StMemWr,
        StBranch,
        StJump,
        StJr,
        StJal,
        StError
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_busy;
    logic          timed_out;

    assign timed_out = (cnt_q == TimeoutCnt);

    // State register and memory wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait-counter and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_busy  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        reg_we    = 1'b0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        alu_src_b = 2'd3;
        alu_op    = AluAdd;
        retire    = 1'b0;
        error     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_busy = 1'b1;
                mem_req  = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StDecode: begin
                case (opcode)
                    OpRtype: begin
                        case (funct)
                            FnAdd, FnSub, FnSlt: state_d = StExecR;
                            FnJr:                state_d = StJr;
                            default:             state_d = StError;
                        endcase
                    end
                    OpAddi, OpXori: state_d = StExecI;
                    OpLw, OpSw:     state_d = StAddr;
                    OpBne:          state_d = StBranch;
                    OpJ:            state_d = StJump;
                    OpJal:          state_d = StJal;
                    default:        state_d = StError;
                endcase
            end
            StExecR: begin
                alu_src_b = 2'd0;
                case (funct)
                    FnSub:   alu_op = AluSub;
                    FnSlt:   alu_op = AluSlt;
                    default: alu_op = AluAdd;
                endcase
                state_d = StWbR;
            end
            StWbR: begin
                reg_we  = 1'b1;
                reg_dst = 2'd1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StExecI: begin
                if (opcode == OpXori) begin
                    alu_src_b = 2'd2;
                    alu_op    = AluXor;
                end else begin
                    alu_src_b = 2'd1;
                    alu_op    = AluAdd;
                end
                state_d = StWbI;
            end
            StWbI: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StAddr: begin
                alu_src_b = 2'd1;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_busy = 1'b1;
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    state_d = StWbMem;
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StWbMem: begin
                reg_we  = 1'b1;
                wb_sel  = 2'd1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StMemWr: begin
                mem_busy = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (timed_out) begin
                    state_d = StError;
                end
            end
            StBranch: begin
                alu_src_b = 2'd0;
                alu_op    = AluSub;
                pc_src    = 2'd1;
                pc_we     = ~alu_zero;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StJr: begin
                pc_we   = 1'b1;
                pc_src  = 2'd3;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                reg_we  = 1'b1;
                reg_dst = 2'd2;
                wb_sel  = 2'd2;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StError: begin
                error = 1'b1;
            end
            default: begin
                state_d = StError;
            end
        endcase

        // Every state change restarts the count, so each memory access starts at zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_busy && !mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are forced quiet while reset is held, so an aborted access drops at once.
        if (!reset_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            addr_sel  = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = 2'd0;
            reg_we    = 1'b0;
            reg_dst   = 2'd0;
            wb_sel    = 2'd0;
            alu_src_b = 2'd3;
            alu_op    = AluAdd;
            retire    = 1'b0;
            error     = 1'b0;
        end
    end

endmodule
